multicycle_controller: RTL and testbench

Sequential control unit for the multicycle RV32I core, generalising the single-cycle main decoder into a state machine. It sequences fetch, decode, execute, memory and writeback over several cycles against a shared instruction/data memory. It resolves all six branch conditions, honours memory wait states, and traps on illegal encodings. It also keeps a retired-instruction counter.

---
 rtl/multicycle_controller_if.sv | 22 ++
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Memory-side handshake between the multicycle controller and the
// shared instruction/data memory.
interface multicycle_controller_if;
    logic mem_req;
    logic MemWrite;
    logic AdrSrc;
    logic mem_ready;

    modport master (
        output mem_req,
        output MemWrite,
        output AdrSrc,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemWrite,
        input  AdrSrc,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing over a shared memory, branch resolution, traps, instret.
module multicycle_controller #(
    parameter bit MEM_WAIT     = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              op,
    input  logic [2:0]              funct3,
    input  logic                    Zero,
    input  logic                    Lt,
    input  logic                    LtU,
    multicycle_controller_if.master mem,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    pc_lsb_clr,
    output logic                    RegWrite,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [1:0]              ResultSrc,
    output logic [2:0]              ImmSrc,
    output logic [2:0]              Load,
    output logic [1:0]              Store,
    output logic                    illegal,
    output logic                    instr_done,
    output logic [CNT_W-1:0]        instret
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
        EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, TRAP
    } state_t;

    state_t state;
    logic   rdy;
    logic   bad;
    logic   take;
    logic   retire;

    // Without wait states the memory is assumed to answer every cycle.
    assign rdy = MEM_WAIT ? mem.mem_ready : 1'b1;

    assign Load       = funct3;
    assign Store      = funct3[1:0];
    assign instr_done = retire;

    always_comb begin
        bad = 1'b0;
        unique case (op)
            OP_LOAD:   bad = funct3 inside {3'b011, 3'b110, 3'b111};
            OP_STORE:  bad = funct3[2] | (funct3[1:0] == 2'b11);
            OP_BRANCH: bad = (funct3[2:1] == 2'b01);
            OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
    end

    always_comb begin
        take = 1'b0;
        unique case (funct3)
            3'b000:  take = Zero;
            3'b001:  take = !Zero;
            3'b100:  take = Lt;
            3'b101:  take = !Lt;
            3'b110:  take = LtU;
            3'b111:  take = !LtU;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        unique case (op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        retire = 1'b0;
        unique case (state)
            MEMWB, ALUWB, BRANCH: retire = 1'b1;
            MEMWRITE:             retire = rdy;
            DECODE:               retire = bad && !ILLEGAL_TRAP;
            default:              retire = 1'b0;
        endcase
        if (reset) retire = 1'b0;
    end

    always_comb begin
        mem.mem_req  = 1'b0;
        mem.MemWrite = 1'b0;
        mem.AdrSrc   = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        pc_lsb_clr   = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        ResultSrc    = 2'b00;
        illegal      = 1'b0;
        unique case (state)
            FETCH: begin
                mem.mem_req = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                IRWrite     = rdy;
                PCWrite     = rdy;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                mem.mem_req = 1'b1;
                mem.AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                mem.mem_req  = 1'b1;
                mem.AdrSrc   = 1'b1;
                mem.MemWrite = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = take;
            end
            JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                pc_lsb_clr = 1'b1;
            end
            LINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            TRAP: illegal = 1'b1;
            default: ;
        endcase
        // Reset aborts whatever is in flight, so nothing may be written.
        if (reset) begin
            mem.mem_req  = 1'b0;
            mem.MemWrite = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            RegWrite     = 1'b0;
            illegal      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            if (retire) instret <= instret + CNT_ONE;
            unique case (state)
                FETCH: if (rdy) state <= DECODE;
                DECODE: begin
                    if (bad) begin
                        state <= ILLEGAL_TRAP ? TRAP : FETCH;
                    end else begin
                        unique case (op)
                            OP_LOAD, OP_STORE: state <= MEMADR;
                            OP_R:              state <= EXECR;
                            OP_I:              state <= EXECI;
                            OP_BRANCH:         state <= BRANCH;
                            OP_JAL:            state <= JAL;
                            OP_JALR:           state <= JALR;
                            OP_LUI:            state <= LUI;
                            OP_AUIPC:          state <= ALUWB;
                            default:           state <= FETCH;
                        endcase
                    end
                end
                MEMADR:       state <= (op == OP_STORE) ? MEMWRITE : MEMREAD;
                MEMREAD:      if (rdy) state <= MEMWB;
                MEMWB:        state <= FETCH;
                MEMWRITE:     if (rdy) state <= FETCH;
                EXECR, EXECI: state <= ALUWB;
                ALUWB:        state <= FETCH;
                BRANCH:       state <= FETCH;
                JAL:          state <= ALUWB;
                JALR:         state <= LINK;
                LINK:         state <= ALUWB;
                LUI:          state <= ALUWB;
                TRAP:         state <= TRAP;
                default:      state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, directed corner
// sequences and randomized instructions against an instruction-level model.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    typedef struct packed {
        logic       mem_req;
        logic       MemWrite;
        logic       AdrSrc;
        logic       IRWrite;
        logic       PCWrite;
        logic       pc_lsb_clr;
        logic       RegWrite;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] ResultSrc;
        logic [2:0] ImmSrc;
        logic [2:0] Load;
        logic [1:0] Store;
        logic       illegal;
        logic       instr_done;
    } obs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       z;
        logic       lt;
        logic       ltu;
        int         cyc;
        int         rw;
        int         mw;
        int         pw;
    } vec_t;

    typedef enum {
        P_F, P_D, P_ADR, P_RD, P_RWB, P_WR, P_XR, P_XI,
        P_WB, P_BR, P_JAL, P_JALR, P_LINK, P_LUI, P_TRAP
    } ph_t;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic zero, lt, ltu;

    logic irw_a, pcw_a, lsb_a, rw_a, ill_a, done_a;
    logic [1:0] sa_a, sb_a, aop_a, res_a, st_a;
    logic [2:0] imm_a, ld_a;
    logic [3:0] instret_a;
    logic irw_b, pcw_b, lsb_b, rw_b, ill_b, done_b;
    logic [1:0] sa_b, sb_b, aop_b, res_b, st_b;
    logic [2:0] imm_b, ld_b;
    logic [31:0] instret_b;
    obs_t oa, ob;

    int n_chk = 0;
    int n_fail = 0;
    int exp_a = 0;
    int exp_b = 0;
    ph_t pq[$];
    vec_t tbl[16];
    logic [6:0] ops[9] = '{OP_LD, OP_ST, OP_R, OP_I, OP_BR,
                           OP_JAL, OP_JR, OP_LUI, OP_AUI};

    multicycle_controller_if ifa();
    multicycle_controller_if ifb();

    multicycle_controller #(
        .MEM_WAIT(1'b1), .ILLEGAL_TRAP(1'b1), .CNT_W(4)
    ) dut_a (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .Zero(zero), .Lt(lt), .LtU(ltu), .mem(ifa),
        .IRWrite(irw_a), .PCWrite(pcw_a), .pc_lsb_clr(lsb_a),
        .RegWrite(rw_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a),
        .ALUOp(aop_a), .ResultSrc(res_a), .ImmSrc(imm_a),
        .Load(ld_a), .Store(st_a), .illegal(ill_a),
        .instr_done(done_a), .instret(instret_a)
    );

    multicycle_controller #(
        .MEM_WAIT(1'b0), .ILLEGAL_TRAP(1'b0), .CNT_W(32)
    ) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .Zero(zero), .Lt(lt), .LtU(ltu), .mem(ifb),
        .IRWrite(irw_b), .PCWrite(pcw_b), .pc_lsb_clr(lsb_b),
        .RegWrite(rw_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b),
        .ALUOp(aop_b), .ResultSrc(res_b), .ImmSrc(imm_b),
        .Load(ld_b), .Store(st_b), .illegal(ill_b),
        .instr_done(done_b), .instret(instret_b)
    );

    assign oa = {ifa.mem_req, ifa.MemWrite, ifa.AdrSrc, irw_a, pcw_a,
                 lsb_a, rw_a, sa_a, sb_a, aop_a, res_a, imm_a, ld_a,
                 st_a, ill_a, done_a};
    assign ob = {ifb.mem_req, ifb.MemWrite, ifb.AdrSrc, irw_b, pcw_b,
                 lsb_b, rw_b, sa_b, sb_b, aop_b, res_b, imm_b, ld_b,
                 st_b, ill_b, done_b};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(logic [6:0] o);
        case (o)
            OP_ST:          return 3'b001;
            OP_BR:          return 3'b010;
            OP_JAL:         return 3'b011;
            OP_LUI, OP_AUI: return 3'b100;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic bit legal();
        case (op)
            OP_LD:   return !(funct3 inside {3'd3, 3'd6, 3'd7});
            OP_ST:   return funct3 <= 3'd2;
            OP_BR:   return !(funct3 inside {3'd2, 3'd3});
            OP_R, OP_I, OP_JAL, OP_JR, OP_LUI, OP_AUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_mem(ph_t p);
        return p inside {P_F, P_RD, P_WR};
    endfunction

    // Phase list of one instruction as the ISA-level walk describes it.
    function automatic void build(bit trap);
        pq.delete();
        pq.push_back(P_F);
        pq.push_back(P_D);
        if (!legal()) begin
            if (trap) pq.push_back(P_TRAP);
            return;
        end
        case (op)
            OP_LD:   begin pq.push_back(P_ADR); pq.push_back(P_RD);
                           pq.push_back(P_RWB); end
            OP_ST:   begin pq.push_back(P_ADR); pq.push_back(P_WR); end
            OP_R:    begin pq.push_back(P_XR); pq.push_back(P_WB); end
            OP_I:    begin pq.push_back(P_XI); pq.push_back(P_WB); end
            OP_BR:   pq.push_back(P_BR);
            OP_JAL:  begin pq.push_back(P_JAL); pq.push_back(P_WB); end
            OP_JR:   begin pq.push_back(P_JALR); pq.push_back(P_LINK);
                           pq.push_back(P_WB); end
            OP_LUI:  begin pq.push_back(P_LUI); pq.push_back(P_WB); end
            default: pq.push_back(P_WB);
        endcase
    endfunction

    function automatic obs_t exp_obs(ph_t p, logic rdy, bit last, bit rst);
        obs_t e;
        logic c;
        e = '0;
        c = 1'b0;
        e.ImmSrc = imm_of(op);
        e.Load = funct3;
        e.Store = funct3[1:0];
        case (p)
            P_F: begin
                e.mem_req = 1'b1; e.ALUSrcB = 2'b10; e.ResultSrc = 2'b10;
                e.IRWrite = rdy; e.PCWrite = rdy;
            end
            P_D:    begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b01; end
            P_ADR:  begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; end
            P_RD:   begin e.mem_req = 1'b1; e.AdrSrc = 1'b1; end
            P_RWB:  begin e.ResultSrc = 2'b01; e.RegWrite = 1'b1; end
            P_WR: begin
                e.mem_req = 1'b1; e.AdrSrc = 1'b1; e.MemWrite = 1'b1;
            end
            P_XR:   begin e.ALUSrcA = 2'b10; e.ALUOp = 2'b10; end
            P_XI: begin
                e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; e.ALUOp = 2'b10;
            end
            P_WB:   e.RegWrite = 1'b1;
            P_BR: begin
                e.ALUSrcA = 2'b10; e.ALUOp = 2'b01;
                case (funct3[2:1])
                    2'b00:   c = zero;
                    2'b10:   c = lt;
                    2'b11:   c = ltu;
                    default: c = 1'b0;
                endcase
                e.PCWrite = c ^ funct3[0];
            end
            P_JAL: begin
                e.PCWrite = 1'b1; e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10;
            end
            P_JALR: begin
                e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; e.ResultSrc = 2'b10;
                e.PCWrite = 1'b1; e.pc_lsb_clr = 1'b1;
            end
            P_LINK: begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; end
            P_LUI:  begin e.ALUSrcA = 2'b11; e.ALUSrcB = 2'b01; end
            default: e.illegal = 1'b1;
        endcase
        e.instr_done = last && (p != P_TRAP) && (rdy || !is_mem(p));
        if (rst) begin
            e.mem_req = 1'b0; e.MemWrite = 1'b0; e.IRWrite = 1'b0;
            e.PCWrite = 1'b0; e.RegWrite = 1'b0; e.illegal = 1'b0;
            e.instr_done = 1'b0;
        end
        return e;
    endfunction

    // Steps DUT A through one legal instruction; bit c of mask is
    // mem_ready in the c-th cycle of the instruction.
    task automatic run_instr(input logic [31:0] mask, output int cycles);
        int idx;
        int c;
        bit adv;
        idx = 0;
        c = 0;
        build(1'b1);
        while (idx < pq.size() && c < 60) begin
            ifa.mem_ready = (c < 32) ? mask[c] : 1'b1;
            @(negedge clk);
            chk($sformatf("A %s c%0d", pq[idx].name(), c), oa,
                exp_obs(pq[idx], ifa.mem_ready, idx == pq.size() - 1, 1'b0));
            adv = !is_mem(pq[idx]) || ifa.mem_ready;
            @(posedge clk);
            #1;
            if (adv) idx++;
            c++;
        end
        chk("A instr timeout", idx, pq.size());
        cycles = c;
    endtask

    initial begin
        int c;
        int cb;
        int rw;
        int mw;
        int pw;
        bit done;

        reset = 1'b1;
        op = '0; funct3 = '0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        ifa.mem_ready = 1'b1;
        ifb.mem_ready = 1'b0;

        tbl[0]  = '{OP_R,   3'd0, 1'b0, 1'b0, 1'b0, 4, 1, 0, 1};
        tbl[1]  = '{OP_I,   3'd0, 1'b0, 1'b0, 1'b0, 4, 1, 0, 1};
        tbl[2]  = '{OP_LD,  3'd2, 1'b0, 1'b0, 1'b0, 5, 1, 0, 1};
        tbl[3]  = '{OP_ST,  3'd0, 1'b0, 1'b0, 1'b0, 4, 0, 1, 1};
        tbl[4]  = '{OP_ST,  3'd2, 1'b0, 1'b0, 1'b0, 4, 0, 1, 1};
        tbl[5]  = '{OP_BR,  3'd0, 1'b1, 1'b0, 1'b0, 3, 0, 0, 2};
        tbl[6]  = '{OP_BR,  3'd0, 1'b0, 1'b1, 1'b1, 3, 0, 0, 1};
        tbl[7]  = '{OP_BR,  3'd1, 1'b1, 1'b0, 1'b0, 3, 0, 0, 1};
        tbl[8]  = '{OP_BR,  3'd4, 1'b0, 1'b1, 1'b0, 3, 0, 0, 2};
        tbl[9]  = '{OP_BR,  3'd5, 1'b0, 1'b1, 1'b0, 3, 0, 0, 1};
        tbl[10] = '{OP_BR,  3'd6, 1'b0, 1'b0, 1'b1, 3, 0, 0, 2};
        tbl[11] = '{OP_BR,  3'd7, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1};
        tbl[12] = '{OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 4, 1, 0, 2};
        tbl[13] = '{OP_JR,  3'd0, 1'b0, 1'b0, 1'b0, 5, 1, 0, 2};
        tbl[14] = '{OP_LUI, 3'd0, 1'b0, 1'b0, 1'b0, 4, 1, 0, 1};
        tbl[15] = '{OP_AUI, 3'd0, 1'b0, 1'b0, 1'b0, 3, 1, 0, 1};

        repeat (2) @(negedge clk);
        chk("reset outputs A", oa, exp_obs(P_F, 1'b1, 1'b0, 1'b1));
        chk("reset outputs B", ob, exp_obs(P_F, 1'b1, 1'b0, 1'b1));
        chk("reset instret A", instret_a, 0);
        chk("reset instret B", instret_b, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (tbl[i]) begin
            op = tbl[i].op; funct3 = tbl[i].f3;
            zero = tbl[i].z; lt = tbl[i].lt; ltu = tbl[i].ltu;
            c = 0; cb = 0; rw = 0; mw = 0; pw = 0; done = 1'b0;
            while (!done && c < 20) begin
                @(negedge clk);
                c++;
                rw += int'(oa.RegWrite);
                mw += int'(oa.MemWrite);
                pw += int'(oa.PCWrite);
                if (ob.instr_done && cb == 0) cb = c;
                done = oa.instr_done;
                @(posedge clk);
                #1;
            end
            exp_a++;
            exp_b++;
            chk($sformatf("vec%0d cycles", i), c, tbl[i].cyc);
            chk($sformatf("vec%0d B cycles", i), cb, tbl[i].cyc);
            chk($sformatf("vec%0d RegWrite", i), rw, tbl[i].rw);
            chk($sformatf("vec%0d MemWrite", i), mw, tbl[i].mw);
            chk($sformatf("vec%0d PCWrite", i), pw, tbl[i].pw);
            chk($sformatf("vec%0d instret A", i), instret_a, exp_a % 16);
        end
        chk("instret A wrap", instret_a, 0);
        chk("instret B", instret_b, exp_b);

        // Illegal op: A traps, B retires it as a NOP.
        op = 7'b0000000; funct3 = 3'd0;
        @(negedge clk);
        chk("ill A fetch", oa, exp_obs(P_F, 1'b1, 1'b0, 1'b0));
        chk("ill B fetch", ob, exp_obs(P_F, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ill A decode", oa, exp_obs(P_D, 1'b1, 1'b0, 1'b0));
        chk("ill B decode", ob, exp_obs(P_D, 1'b1, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        exp_b++;
        chk("ill B instret", instret_b, exp_b);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("trap A c%0d", k), oa,
                exp_obs(P_TRAP, 1'b1, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        chk("trap instret A", instret_a, exp_a % 16);
        reset = 1'b1;
        @(negedge clk);
        chk("trap reset A", oa, exp_obs(P_TRAP, 1'b1, 1'b0, 1'b1));
        chk("reset enables B",
            {ob.mem_req, ob.MemWrite, ob.IRWrite, ob.PCWrite,
             ob.RegWrite, ob.illegal, ob.instr_done}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_a = 0;
        exp_b = 0;
        chk("post-trap instret A", instret_a, 0);
        chk("post-trap instret B", instret_b, 0);

        // lw with two wait cycles in the memory read.
        op = OP_LD; funct3 = 3'd2;
        run_instr(32'hFFFF_FFE7, c);
        exp_a++;
        chk("lw wait cycles", c, 7);
        chk("lw wait instret A", instret_a, exp_a % 16);

        for (int k = 0; k < 40; k++) begin
            do begin
                op = ops[$urandom_range(8)];
                funct3 = 3'($urandom_range(7));
            end while (!legal());
            zero = 1'($urandom_range(1));
            lt = 1'($urandom_range(1));
            ltu = 1'($urandom_range(1));
            run_instr($urandom | $urandom, c);
            exp_a++;
            chk($sformatf("rand%0d instret A", k), instret_a, exp_a % 16);
        end

        // Reset while a store waits on memory.
        op = OP_ST; funct3 = 3'd2; ifa.mem_ready = 1'b1;
        build(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("st %s", pq[k].name()), oa,
                exp_obs(pq[k], 1'b1, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
        ifa.mem_ready = 1'b0;
        @(negedge clk);
        chk("st wait", oa, exp_obs(P_WR, 1'b0, 1'b1, 1'b0));
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("st reset", oa, exp_obs(P_WR, 1'b0, 1'b1, 1'b1));
        @(posedge clk);
        #1 reset = 1'b0;
        ifa.mem_ready = 1'b1;
        @(negedge clk);
        chk("st after reset", oa, exp_obs(P_F, 1'b1, 1'b0, 1'b0));
        chk("st after reset instret", instret_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
